// File: rtl/user_interface_pkg.sv
// Shared definitions for the user-interface input front end: arbiter states,
// button bit positions and the default debounce window.
package user_interface_pkg;

  // 10 ms at 100 MHz
  localparam logic [19:0] DEFAULT_DEBOUNCE_COUNT = 20'd999999;

  // Bit positions inside the {result, flags, instruction} button vectors
  localparam int BTN_INSTR  = 0;
  localparam int BTN_FLAGS  = 1;
  localparam int BTN_RESULT = 2;

  // Arbiter states; the encoding is fixed so the state register is readable on a probe
  typedef enum logic [1:0] {
    UI_IDLE        = 2'd0,
    UI_HOLD_INSTR  = 2'd1,
    UI_HOLD_FLAGS  = 2'd2,
    UI_HOLD_RESULT = 2'd3
  } ui_state_e;

endpackage

// File: rtl/input_debouncer.sv
// One board-input channel: two-flop synchronizer, stability counter, accepted
// level register and registered one-cycle rise/fall pulses.
module input_debouncer
  import user_interface_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_COUNT = DEFAULT_DEBOUNCE_COUNT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  // Last count value before a new level is accepted
  localparam logic [19:0] TERMINAL = DEBOUNCE_COUNT - 20'd1;

  logic        meta_q;
  logic        sync_q;
  logic        stable_q;
  logic        stable_d;
  logic [19:0] cnt_q;
  logic [19:0] cnt_d;
  logic        rise_q;
  logic        rise_d;
  logic        fall_q;
  logic        fall_d;
  logic        terminal;

  assign terminal = (cnt_q == TERMINAL);

  // Bring the asynchronous pin into the clock domain before anything looks at it
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= raw_i;
      sync_q <= meta_q;
    end
  end

  // Count consecutive cycles of disagreement; any return to the old level restarts the window
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (sync_q == stable_q) begin
      cnt_d = 20'd0;
    end else if (terminal) begin
      stable_d = sync_q;
      cnt_d    = 20'd0;
      rise_d   = sync_q & ~stable_q;
      fall_d   = ~sync_q & stable_q;
    end else begin
      cnt_d = cnt_q + 20'd1;
    end
  end

  // Accepted level, counter and edge pulses update together so a pulse lines up with the new level
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stable_q <= 1'b0;
      cnt_q    <= 20'd0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign level_o = stable_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/user_input_conditioner.sv
// Board-input front end: debounces three check buttons and the CPU-start switch,
// produces edge pulses and grants at most one held check request at a time.
module user_input_conditioner
  import user_interface_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_COUNT = DEFAULT_DEBOUNCE_COUNT
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_button_instruction,
  input  logic       i_button_flags,
  input  logic       i_button_result,
  input  logic       i_switch_start_cpu,
  output logic       button_check_instruction,
  output logic       button_check_flags,
  output logic       button_check_result,
  output logic       switch_start_cpu,
  output logic       o_start_pulse,
  output logic [2:0] o_btn_press,
  output logic [2:0] o_btn_release
);

  logic [2:0] btnRaw;
  logic [2:0] btnLevel;
  logic       switchFall;
  logic       unusedSwitchFall;
  ui_state_e  state_q;
  ui_state_e  state_d;

  assign btnRaw[BTN_INSTR]  = i_button_instruction;
  assign btnRaw[BTN_FLAGS]  = i_button_flags;
  assign btnRaw[BTN_RESULT] = i_button_result;

  // One debouncer per push-button
  for (genvar b = 0; b < 3; b++) begin : g_btn
    input_debouncer #(
      .DEBOUNCE_COUNT(DEBOUNCE_COUNT)
    ) u_btn (
      .clk_i  (i_clk),
      .rst_i  (i_rst),
      .raw_i  (btnRaw[b]),
      .level_o(btnLevel[b]),
      .rise_o (o_btn_press[b]),
      .fall_o (o_btn_release[b])
    );
  end

  // The start switch only needs its level and its rising edge
  input_debouncer #(
    .DEBOUNCE_COUNT(DEBOUNCE_COUNT)
  ) u_switch (
    .clk_i  (i_clk),
    .rst_i  (i_rst),
    .raw_i  (i_switch_start_cpu),
    .level_o(switch_start_cpu),
    .rise_o (o_start_pulse),
    .fall_o (switchFall)
  );

  assign unusedSwitchFall = switchFall;

  // Arbiter state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= UI_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant by fixed priority from idle; a held grant ignores other buttons until its own release
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      UI_IDLE: begin
        if (btnLevel[BTN_INSTR]) begin
          state_d = UI_HOLD_INSTR;
        end else if (btnLevel[BTN_FLAGS]) begin
          state_d = UI_HOLD_FLAGS;
        end else if (btnLevel[BTN_RESULT]) begin
          state_d = UI_HOLD_RESULT;
        end
      end
      UI_HOLD_INSTR: begin
        if (!btnLevel[BTN_INSTR]) state_d = UI_IDLE;
      end
      UI_HOLD_FLAGS: begin
        if (!btnLevel[BTN_FLAGS]) state_d = UI_IDLE;
      end
      UI_HOLD_RESULT: begin
        if (!btnLevel[BTN_RESULT]) state_d = UI_IDLE;
      end
      default: state_d = UI_IDLE;
    endcase
  end

  assign button_check_instruction = (state_q == UI_HOLD_INSTR);
  assign button_check_flags       = (state_q == UI_HOLD_FLAGS);
  assign button_check_result      = (state_q == UI_HOLD_RESULT);

endmodule

// File: doc/user_input_conditioner.md
# user_input_conditioner

Board-input front end for the user interface: synchronizes and debounces the three "check" push-buttons and the CPU-start slide switch, emits one-cycle edge pulses, and arbitrates the buttons into mutually exclusive, held-level check requests. Its outputs drive the seven-segment display controller's `button_check_*` and `switch_start_cpu` inputs and the CPU start logic. All board pins are asynchronous to `i_clk`.

## Interface
- `DEBOUNCE_COUNT`, default `20'd999999`: consecutive stable cycles required to accept a level change (10 ms at 100 MHz); legal range 1..2^20-1.
- `i_clk` in 1: system clock.
- `i_rst` in 1: reset, asynchronous, active-high. The block has one clock, `i_clk`.
- `i_button_instruction` in 1: raw push-button, active-high.
- `i_button_flags` in 1: raw push-button, active-high.
- `i_button_result` in 1: raw push-button, active-high.
- `i_switch_start_cpu` in 1: raw slide switch.
- `button_check_instruction` out 1: arbitrated held request; reset 0.
- `button_check_flags` out 1: arbitrated held request; reset 0.
- `button_check_result` out 1: arbitrated held request; reset 0.
- `switch_start_cpu` out 1: debounced switch level; reset 0.
- `o_start_pulse` out 1: one-cycle pulse on debounced switch 0→1; reset 0.
- `o_btn_press` out 3: one-cycle pulses on debounced button 0→1, with bit order {result, flags, instruction}; reset 0.
- `o_btn_release` out 3: one-cycle pulses on debounced button 1→0, same bit order; reset 0.

## Operation
- Per channel (×4):
  - Two-flop synchronizer.
  - Stable register `stable`, reset 0.
  - Counter `cnt[19:0]`, reset 0.
- Each cycle of a channel:
  - If `sync == stable`: `cnt <= 0`.
  - Otherwise, if `cnt == DEBOUNCE_COUNT-1`: `stable <= sync`, `cnt <= 0`.
  - Otherwise: `cnt <= cnt+1`.
  - Any glitch back to the old level restarts the count.
- Edge pulses are registered and asserted in the same cycle `stable` takes its new value:
  - `rise` = `sync & ~stable & terminal`.
  - `fall` = `~sync & stable & terminal`.
  - `terminal` means `cnt == DEBOUNCE_COUNT-1`.
- Arbiter FSM states: IDLE, HOLD_INSTR, HOLD_FLAGS, HOLD_RESULT. Encoding is 2'd0..3, reset IDLE.
- In IDLE, the next state is chosen by priority among the debounced button levels: instruction, then flags, then result. If no button level is high, the FSM stays in IDLE.
- In HOLD_X, the FSM stays while debounced X is 1, and goes to IDLE when X is 0. Other buttons are ignored while holding.
- After IDLE is re-entered, a still-held button is granted on the next cycle. A one-cycle all-zero gap is therefore required between grants.
- `button_check_*` are decoded from the state register: exactly one high in a HOLD state, none in IDLE.
- `switch_start_cpu` is the switch channel's `stable`. `o_start_pulse` is that channel's rise pulse.

## Timing
- Latency from a pin change to a debounced level or edge pulse is 2 + DEBOUNCE_COUNT cycles. The pin must hold throughout.
- The FSM grant changes one cycle after the debounced level changes. Pin to `button_check_*` is therefore 3 + DEBOUNCE_COUNT cycles.
- A bounce shorter than DEBOUNCE_COUNT consecutive cycles produces no output change and no pulse.
- Pulses are exactly one cycle wide. Press and release of the same channel can never coincide.
- Simultaneous debounced rises of several buttons in the same cycle: all press pulses fire, and only the highest-priority button is granted.
- Reset mid-operation clears all synchronizers, counters, stable registers, pulses and the FSM immediately.
- A level held through reset deassertion is re-debounced. Its press pulse (or `o_start_pulse`) fires 2 + DEBOUNCE_COUNT cycles after the first clock edge following release.
- Counter width is 20 bits and the counter never exceeds DEBOUNCE_COUNT-1, so no wrap is possible.

## Structure
- Shared package `user_interface_pkg` holds:
  - FSM state localparams (`UI_IDLE`, `UI_HOLD_INSTR`, `UI_HOLD_FLAGS`, `UI_HOLD_RESULT`).
  - Button bit indices (`BTN_INSTR=0`, `BTN_FLAGS=1`, `BTN_RESULT=2`).
  - Default `DEBOUNCE_COUNT`.
- Sub-module `input_debouncer` covers one channel (synchronizer, counter, stable register, rise/fall pulses) and is parameterized by `DEBOUNCE_COUNT`. The top instantiates it 4 times and adds the arbiter FSM.

## Test plan
All scenarios use `DEBOUNCE_COUNT=4`.
- Clean press of instruction at cycle 0, held:
  - `o_btn_press[0]` high in cycle 6 only.
  - `button_check_instruction` = 1 from cycle 7.
  - Release at cycle 20: `o_btn_release[0]` at cycle 26, grant drops at cycle 27.
- Bouncy flags input (1,0,1,1,0,1,1,1,1,…):
  - No pulse until 4 consecutive synchronized highs, then exactly one `o_btn_press[1]`.
  - Bursts of fewer than 4 cycles never change `button_check_flags`.
- Flags and result pressed in the same cycle: both press bits pulse together, and only `button_check_flags` goes high.
- Flags held, then instruction pressed:
  - Instruction is ignored while flags is held.
  - After flags is released: one idle cycle with all grants 0, then `button_check_instruction` = 1.
- Switch 0→1:
  - `switch_start_cpu` = 1 and `o_start_pulse` high for exactly one cycle at cycle 6.
  - Switch 1→0 produces no start pulse.
- Assert `i_rst` mid-hold while a button is still pressed:
  - All outputs go to 0 asynchronously.
  - After release: the press pulse fires again at cycle 6 and the grant returns at cycle 7.
